// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA sync timing plus black / colour-bar / checkerboard / gradient patterns.
// Optional macro VGA_BORDER_EN paints the outermost active pixel ring full-scale white.
module vga_pattern_gen #(
    parameter int   H_ACTIVE   = 800,
    parameter int   H_FP       = 40,
    parameter int   H_SYNC     = 128,
    parameter int   H_BP       = 88,
    parameter int   V_ACTIVE   = 600,
    parameter int   V_FP       = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BP       = 23,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   CLK_DIV    = 2,
    parameter int   COLOR_W    = 4,
    parameter int   CHECK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [2:0]         controllers,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               de,
    output logic [15:0]        hcount,
    output logic [15:0]        vcount,
    output logic               pix_en,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic [7:0]         frame_cnt;
    logic [1:0]         mode_q;
    logic [15:0]        bar_sub;
    logic [2:0]         bar_idx;
    logic               h_last, v_last;
    logic               hs_act, vs_act, active;
    logic [2:0]         bar_rgb;
    logic [COLOR_W-1:0] pat_r, pat_g, pat_b, pat_lvl;

    assign pix_en      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_last      = (hcount == 16'(H_TOTAL - 1));
    assign v_last      = (vcount == 16'(V_TOTAL - 1));
    assign frame_start = pix_en && h_last && v_last;

    always_ff @(posedge clk) begin
        if (rst || pix_en) div_cnt <= '0;
        else               div_cnt <= div_cnt + DIV_W'(1);
    end

    // Raster counters, frame bookkeeping and the divider-free bar tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount    <= '0;
            vcount    <= '0;
            mode_q    <= '0;
            frame_cnt <= '0;
            bar_sub   <= '0;
            bar_idx   <= '0;
        end else if (pix_en) begin
            hcount <= h_last ? 16'd0 : hcount + 16'd1;
            if (h_last) vcount <= v_last ? 16'd0 : vcount + 16'd1;
            if (frame_start) begin
                mode_q    <= mode;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (h_last) begin
                bar_sub <= '0;
                bar_idx <= '0;
            end else if (bar_sub == 16'(BAR_W - 1)) begin
                bar_sub <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_sub <= bar_sub + 16'd1;
            end
        end
    end

    assign hs_act = (hcount >= 16'(H_ACTIVE + H_FP)) && (hcount < 16'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_act = (vcount >= 16'(V_ACTIVE + V_FP)) && (vcount < 16'(V_ACTIVE + V_FP + V_SYNC));
    assign active = (hcount < 16'(H_ACTIVE)) && (vcount < 16'(V_ACTIVE));
    assign pat_lvl = hcount[COLOR_W+1:2] + frame_cnt[COLOR_W-1:0];

    always_comb begin
        bar_rgb = 3'b000;
        pat_r   = '0;
        pat_g   = '0;
        pat_b   = '0;
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
        case (mode_q)
            2'd1: begin
                pat_r = {COLOR_W{bar_rgb[2]}};
                pat_g = {COLOR_W{bar_rgb[1]}};
                pat_b = {COLOR_W{bar_rgb[0]}};
            end
            2'd2: begin
                pat_r = {COLOR_W{hcount[CHECK_LOG2] ^ vcount[CHECK_LOG2]}};
                pat_g = pat_r;
                pat_b = pat_r;
            end
            2'd3: begin
                pat_r = pat_lvl;
                pat_g = pat_lvl;
                pat_b = pat_lvl;
            end
            default: ;
        endcase
`ifdef VGA_BORDER_EN
        if (hcount == 16'd0 || hcount == 16'(H_ACTIVE - 1) ||
            vcount == 16'd0 || vcount == 16'(V_ACTIVE - 1)) begin
            pat_r = '1;
            pat_g = '1;
            pat_b = '1;
        end
`else
`endif
        // Blanking wins over everything, channel masking is the final stage.
        if (!active) begin
            pat_r = '0;
            pat_g = '0;
            pat_b = '0;
        end
        if (!controllers[0]) pat_r = '0;
        if (!controllers[1]) pat_g = '0;
        if (!controllers[2]) pat_b = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            de    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (pix_en) begin
            hsync <= hs_act ? HS_POL : ~HS_POL;
            vsync <= vs_act ? VS_POL : ~VS_POL;
            de    <= active;
            red   <= pat_r;
            green <= pat_g;
            blue  <= pat_b;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: small-raster timing instance (a) and 800-wide pattern instance (b)
// checked by fixed vectors, hand sequences and a cycle-count based reference model.
module tb_vga_pattern_gen;

  localparam int HA = 800, HFP = 40, HSY = 128, HBP = 88, HT = HA + HFP + HSY + HBP;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1, VT = VA + VFP + VSY + VBP;
  localparam int FR = HT * VT;
  localparam int BAR_W = HA / 8;
  localparam int CL = 5;
  localparam int W = 48;
`ifdef VGA_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  typedef struct {
    int         mode;
    logic [2:0] ctrl;
    int         h;
    int         v;
    logic       de;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic [1:0] mode_a, mode_b;
  logic [2:0] ctrl_a, ctrl_b;
  logic hsync_a, vsync_a, de_a, pix_en_a, frame_start_a;
  logic hsync_b, vsync_b, de_b, pix_en_b, frame_start_b;
  logic [3:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic [15:0] hcount_a, vcount_a, hcount_b, vcount_b;

  vga_pattern_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
                    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst_a), .mode(mode_a), .controllers(ctrl_a),
    .hsync(hsync_a), .vsync(vsync_a), .red(red_a), .green(green_a), .blue(blue_a),
    .de(de_a), .hcount(hcount_a), .vcount(vcount_a), .pix_en(pix_en_a),
    .frame_start(frame_start_a));

  vga_pattern_gen #(.V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst_b), .mode(mode_b), .controllers(ctrl_b),
    .hsync(hsync_b), .vsync(vsync_b), .red(red_b), .green(green_b), .blue(blue_b),
    .de(de_b), .hcount(hcount_b), .vcount(vcount_b), .pix_en(pix_en_b),
    .frame_start(frame_start_b));

  int n_checks = 0;
  int n_err = 0;
  int pb = 0;
  int lat_b = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {hsync, vsync, de, r, g, b} for pixel (h,v) straight from the pattern rules.
  function automatic logic [14:0] pixel_ref(input int h, input int v, input int m, input int fc,
                                            input logic [2:0] ctrl);
    logic hs, vs, de;
    logic [3:0] r, g, b;
    logic [2:0] rgb;
    int idx;
    hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
    vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
    de = (h < HA) && (v < VA);
    r = 0; g = 0; b = 0; rgb = 0;
    if (m == 1) begin
      idx = h / BAR_W;
      if (idx > 7) idx = 7;
      case (idx)
        0: rgb = 3'b111;
        1: rgb = 3'b110;
        2: rgb = 3'b011;
        3: rgb = 3'b010;
        4: rgb = 3'b101;
        5: rgb = 3'b100;
        6: rgb = 3'b001;
        default: rgb = 3'b000;
      endcase
      r = rgb[2] ? 4'hF : 4'h0;
      g = rgb[1] ? 4'hF : 4'h0;
      b = rgb[0] ? 4'hF : 4'h0;
    end else if (m == 2) begin
      if ((((h >> CL) ^ (v >> CL)) & 1) == 1) begin r = 4'hF; g = 4'hF; b = 4'hF; end
    end else if (m == 3) begin
      r = 4'(((h >> 2) + fc) % 16);
      g = r;
      b = r;
    end
    if (BORDER && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)) begin
      r = 4'hF; g = 4'hF; b = 4'hF;
    end
    if (!de) begin r = 0; g = 0; b = 0; end
    if (!ctrl[0]) r = 0;
    if (!ctrl[1]) g = 0;
    if (!ctrl[2]) b = 0;
    return {hs, vs, de, r, g, b};
  endfunction

  // Model of instance b: pixel index pb = clock edges since reset release (one pixel per clk).
  task automatic model_step();
    int h, v, fc;
    logic [W-1:0] e;
    bit chk;
    if (rst_b) begin
      pb = 0;
      lat_b = 0;
      e = '0;
      chk = 1'b1;
    end else begin
      h = pb % HT;
      v = (pb / HT) % VT;
      fc = (pb / FR) % 256;
      e[14:0] = pixel_ref(h, v, lat_b, fc, ctrl_b);
      if (pb % FR == FR - 1) lat_b = mode_b;
      pb++;
      e[W-1:15] = {16'(pb % HT), 16'((pb / HT) % VT), (pb % FR == FR - 1)};
      chk = (h == 0 || h == 1 || h == 99 || h == 100 || h == 799 || h == 800 || h == 839 ||
             h == 840 || h == 967 || h == 968 || h == HT - 1 || e[14] ||
             $urandom_range(0, 31) == 0);
    end
    if (chk) exp_q.push_back(e);
  endtask

  task automatic tick();
    logic [W-1:0] e, act;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {hcount_b, vcount_b, frame_start_b, hsync_b, vsync_b, de_b, red_b, green_b, blue_b};
      check("stream_b", act, e);
    end
  endtask

  task automatic step_a();
    int n = 0;
    while (!pix_en_a && n < 8) begin tick(); n++; end
    if (n >= 8) check("a_pix_timeout", 1, 0);
    tick();
  endtask

  task automatic wait_frame_b();
    int n = 0;
    while (!frame_start_b && n < 2 * FR) begin tick(); n++; end
    if (n >= 2 * FR) check("b_frame_timeout", 1, 0);
    tick();
  endtask

  task automatic wait_pix_b(input int h, input int v);
    int n = 0;
    while (!(hcount_b == 16'(h) && vcount_b == 16'(v)) && n < 2 * FR) begin tick(); n++; end
    if (n >= 2 * FR) check("b_pixel_timeout", 1, 0);
    tick();
  endtask

  initial begin
    int k, first_h, run, cyc, vs_cnt, cur_mode;
    bit ended;
    logic [3:0] bw;
    rst_a = 1; rst_b = 1;
    mode_a = 0; ctrl_a = 3'b111;
    mode_b = 0; ctrl_b = 3'b111;

    repeat (3) begin
      tick();
      check("a_reset", {hsync_a, vsync_a, de_a, red_a, green_a, blue_a}, 15'h0);
    end
    rst_a = 0; rst_b = 0;

    k = 0;
    while (k < 8) begin
      k++;
      if (pix_en_a) break;
      tick();
    end
    check("a_first_pix_en", k, 2);

    first_h = -1; run = 0; ended = 0;
    for (int i = 0; i < 48; i++) begin
      step_a();
      if (hsync_a) begin
        if (first_h < 0) first_h = hcount_a;
        if (!ended) run++;
      end else if (first_h >= 0) begin
        ended = 1;
      end
    end
    check("a_hsync_start", first_h, 19);
    check("a_hsync_width", run, 4);

    k = 0;
    while (!frame_start_a && k < 1200) begin tick(); k++; end
    if (k >= 1200) check("a_frame_timeout", 1, 0);
    tick();
    cyc = 1; vs_cnt = 0;
    while (!frame_start_a && cyc < 1200) begin
      if (vsync_a) vs_cnt++;
      tick();
      cyc++;
    end
    check("a_frame_period", cyc, 576);
    check("a_vsync_cycles", vs_cnt, 96);

    bw = BORDER ? 4'hF : 4'h0;
    vecs[0]  = '{1, 3'b111, 0,   1, 1'b1, 4'hF, 4'hF, 4'hF};
    vecs[1]  = '{1, 3'b111, 100, 1, 1'b1, 4'hF, 4'hF, 4'h0};
    vecs[2]  = '{1, 3'b111, 799, 1, 1'b1, bw,   bw,   bw};
    vecs[3]  = '{1, 3'b111, 800, 1, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[4]  = '{1, 3'b111, 250, 2, 1'b1, 4'h0, 4'hF, 4'hF};
    vecs[5]  = '{1, 3'b011, 350, 2, 1'b1, 4'h0, 4'hF, 4'h0};
    vecs[6]  = '{1, 3'b101, 450, 2, 1'b1, 4'hF, 4'h0, 4'hF};
    vecs[7]  = '{0, 3'b111, 1,   1, 1'b1, 4'h0, 4'h0, 4'h0};
    vecs[8]  = '{0, 3'b111, 0,   2, 1'b1, bw,   bw,   bw};
    vecs[9]  = '{2, 3'b111, 10,  1, 1'b1, 4'h0, 4'h0, 4'h0};
    vecs[10] = '{2, 3'b111, 40,  1, 1'b1, 4'hF, 4'hF, 4'hF};
    vecs[11] = '{2, 3'b001, 33,  2, 1'b1, 4'hF, 4'h0, 4'h0};
    cur_mode = 0;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].mode != cur_mode) begin
        mode_b = 2'(vecs[i].mode);
        wait_frame_b();
        cur_mode = vecs[i].mode;
      end
      ctrl_b = vecs[i].ctrl;
      wait_pix_b(vecs[i].h, vecs[i].v);
      check($sformatf("vec%0d", i), {de_b, red_b, green_b, blue_b},
            {vecs[i].de, vecs[i].r, vecs[i].g, vecs[i].b});
    end

    ctrl_b = 3'b111;
    wait_pix_b(0, 1);
    mode_b = 1;
    wait_pix_b(10, 2);
    check("latch_old_mode", {red_b, green_b, blue_b}, 12'h000);
    wait_frame_b();
    wait_pix_b(10, 1);
    check("latch_new_mode", {red_b, green_b, blue_b}, 12'hFFF);

    wait_pix_b(300, 2);
    rst_b = 1;
    tick();
    check("b_mid_reset", {hcount_b, vcount_b, hsync_b, vsync_b, de_b, red_b, green_b, blue_b},
          47'h0);
    rst_b = 0;
    mode_b = 3;
    ctrl_b = 3'b010;
    repeat (3) wait_frame_b();
    wait_pix_b(8, 1);
    check("gradient_mask", {red_b, green_b, blue_b}, 12'h050);

    repeat (FR + 200) begin
      if ($urandom_range(0, 63) == 0) begin
        mode_b = 2'($urandom_range(0, 3));
        ctrl_b = 3'($urandom_range(0, 7));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator, successor to the fixed 800x600 letter renderer. It generates hsync/vsync from configurable porch/sync parameters, derives the pixel strobe from the system clock with an integer divider, and renders one of four selectable test patterns with per-channel enables. It sits between the board clock and the VGA DAC pins. The pattern mode is latched once per frame.

## Interface
- H_ACTIVE, 800: visible pixels per line
- H_FP, 40 / H_SYNC, 128 / H_BP, 88: horizontal front porch, sync and back porch, in pixels
- V_ACTIVE, 600: visible lines
- V_FP, 1 / V_SYNC, 4 / V_BP, 23: vertical porches and sync, in lines
- HS_POL, 1 / VS_POL, 1: active level of hsync/vsync
- CLK_DIV, 2: clk cycles per pixel, ≥1
- COLOR_W, 4: bits per colour channel
- CHECK_LOG2, 5: checkerboard square size, 2^CHECK_LOG2 pixels
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  0 black, 1 colour bars, 2 checkerboard, 3 scrolling grey gradient
- controllers  in  3  channel enables {B,G,R}; a 0 forces that channel to 0
- hsync, vsync  out  1  sync outputs
- red, green, blue  out  COLOR_W  pixel colour
- de  out  1  active-video flag, aligned with the colour outputs
- hcount  out  16  current horizontal counter
- vcount  out  16  current vertical counter
- pix_en  out  1  one-clk pixel strobe
- frame_start  out  1  one-clk pulse on the pix_en that wraps both counters to 0,0

## Operation
- Local totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
- Line order, starting from 0: active, front porch, sync, back porch. hcount ∈ [0, H_TOTAL-1]; vcount ∈ [0, V_TOTAL-1].
- Pixel divider counts 0..CLK_DIV-1. pix_en=1 when it is at CLK_DIV-1. With CLK_DIV=1, pix_en is high every cycle.
- Counter update on pix_en:
  - hcount increments and wraps at H_TOTAL-1.
  - On that wrap, vcount increments and wraps at V_TOTAL-1.
- Sync is active when the counter is in [ACTIVE+FP, ACTIVE+FP+SYNC-1]; hsync then drives HS_POL, otherwise ~HS_POL. vsync works the same way with V parameters and VS_POL.
- de = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- mode_q latches mode when frame_start fires. It is 0 after reset. A mid-frame change of mode has no visible effect until the next frame.
- frame_cnt (8-bit) increments on each frame_start and wraps 255→0.
- Colour bars:
  - BAR_W = H_ACTIVE/8 (integer division).
  - A sub-counter and a 3-bit bar index both reset at hcount=0. The index advances when the sub-counter reaches BAR_W-1 and saturates at 7.
  - No divider in hardware.
  - Bars 0..7: white, yellow, cyan, green, magenta, red, blue, black. Full-scale = all ones.
- Checkerboard: white when hcount[CHECK_LOG2] ^ vcount[CHECK_LOG2] = 1, else black.
- Gradient: level = hcount[COLOR_W+1:2] + frame_cnt[COLOR_W-1:0], truncated to COLOR_W bits, on all three channels.
- Outside active video, all colour channels are 0 regardless of mode or the border feature.
- Channel masking by controllers is applied last.

## Timing
- All state changes only on pix_en, except the divider.
- Pipeline latency is one pixel. hsync, vsync, de and colour register on pix_en from the pre-increment counters. They are mutually aligned and lag hcount/vcount by one pixel.
- frame_start and pix_en are combinational from registered state, with no added latency.
- Reset values:
  - Divider, hcount, vcount, frame_cnt, mode_q, bar counters: 0.
  - hsync = ~HS_POL, vsync = ~VS_POL, de = 0, colours = 0.
- Reset asserted mid-frame returns every register to its reset value on the next clk edge. The first pix_en after release occurs CLK_DIV cycles later.
- If mode changes on the same edge as frame_start, the new value is latched.

## Configuration
- VGA_BORDER_EN defined: the outermost active pixel ring is forced to full-scale white before channel masking, in every mode including 0. The ring is hcount ∈ {0, H_ACTIVE-1} or vcount ∈ {0, V_ACTIVE-1}.
- VGA_BORDER_EN undefined: no border; pattern pixels are output unchanged.

## Test plan
- Reset and divider (CLK_DIV=2, small params H 16/2/4/2, V 8/1/2/1):
  - Hold rst for 3 cycles, then release.
  - Required: hsync=vsync=~POL, colours 0, and pix_en first high 2 cycles after release.
  - Required: hsync asserts for exactly 4 pixels starting 1 pixel after hcount=18.
- Frame wrap: run 2 frames with the same small params. Required: frame_start period = 24×12×2 = 576 clk, and vsync active for 2 lines.
- Colour bars (default params, mode=1, controllers=3'b111):
  - Required: pixel 0 = F/F/F, pixel 100 = F/F/0, pixel 799 = 0/0/0.
  - Required: pixel 800 (front porch) = 0 with de=0.
- Mode latching:
  - Switch mode 2→1 at vcount=300.
  - Required: checkerboard continues to the end of the frame; bars appear from the next frame_start.
- Channel mask and gradient:
  - mode=3, controllers=3'b010, frame_cnt=3.
  - Required: red=blue=0, green at hcount=8 equals 5.
- Border (VGA_BORDER_EN defined, mode=0):
  - Required: pixel (0,0) and (799,599) = F/F/F; pixel (1,1) = 0.
  - Without the macro: all pixels 0.
